// File: rtl/elab_seq_gen_if.sv
// Request/status bundle for elab_seq_gen: master is the test sequencer, slave is the generator.
// ELAB_SEQ_GEN_CORRUPT_EN adds the corrupt/corrupt_idx request fields.
interface elab_seq_gen_if #(
    parameter int WIDTH = 4
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // start is a request qualified by ready: it is taken on a rising edge where
    // start=1 and ready=1; a start seen while ready=0 is dropped and counted.
    logic             start;
    logic             ready;
    logic             trig;
    logic [WIDTH-1:0] vect;
    logic             busy;
    logic             done;
    logic [7:0]       drop_cnt;
    logic             fsm_state;
`ifdef ELAB_SEQ_GEN_CORRUPT_EN
    logic             corrupt;
    logic [IW-1:0]    corrupt_idx;
`endif

    modport master (
        output start
`ifdef ELAB_SEQ_GEN_CORRUPT_EN
        , corrupt, corrupt_idx
`endif
        , input ready, trig, vect, busy, done, drop_cnt, fsm_state
    );

    modport slave (
        input start
`ifdef ELAB_SEQ_GEN_CORRUPT_EN
        , corrupt, corrupt_idx
`endif
        , output ready, trig, vect, busy, done, drop_cnt, fsm_state
    );
endinterface

// File: rtl/elab_seq_gen.sv
// Walking-one stimulus generator: trig pulse, then vect MSB..LSB, one step every GAP cycles.
// ELAB_SEQ_GEN_CORRUPT_EN blanks one chosen step to provoke a checker failure.
module elab_seq_gen #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input logic            clk,
    input logic            rst_n,
    elab_seq_gen_if.slave  bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = $clog2(GAP + 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
    localparam logic [HW-1:0] HC_TOP  = HW'(GAP - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("elab_seq_gen: WIDTH must be >= 2");
        end
    endgenerate

    logic [0:0]    state_q;
    logic [HW-1:0] hc_q;
    logic [IW-1:0] idx_q;
    logic          trig_q;
    logic [7:0]    drop_q;
    logic          last_step;
    logic          ready;
    logic          accept;
    logic          blank;

    // vect is decoded from idx, so it is one-hot exactly while RUN and 0 otherwise.
    assign last_step = (state_q == RUN) && (hc_q == HC_TOP) && (idx_q == '0);
    assign ready     = (state_q == IDLE) || last_step;
    assign accept    = bus.start && ready;

`ifdef ELAB_SEQ_GEN_CORRUPT_EN
    logic          corrupt_q;
    logic [IW-1:0] corrupt_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corrupt_q     <= 1'b0;
            corrupt_idx_q <= '0;
        end else if (accept) begin
            corrupt_q     <= bus.corrupt;
            corrupt_idx_q <= bus.corrupt_idx;
        end
    end

    assign blank = corrupt_q && (idx_q == corrupt_idx_q);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hc_q    <= '0;
            idx_q   <= '0;
            trig_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            trig_q <= accept;
            if (bus.start && !ready && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            // Acceptance in the final step restarts with no idle gap.
            if (accept) begin
                state_q <= RUN;
                hc_q    <= '0;
                idx_q   <= IDX_TOP;
            end else if (state_q == RUN) begin
                if (hc_q != HC_TOP) begin
                    hc_q <= hc_q + HW'(1);
                end else if (idx_q != '0) begin
                    idx_q <= idx_q - IW'(1);
                    hc_q  <= '0;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.trig      = trig_q;
    assign bus.vect      = ((state_q == RUN) && !blank) ? (WIDTH'(1) << idx_q) : '0;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = last_step;
    assign bus.drop_cnt  = drop_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_elab_seq_gen.sv
// Directed bench for elab_seq_gen: WIDTH=4 with GAP=1 and GAP=3 instances.
// Corrupt-step vectors are added when ELAB_SEQ_GEN_CORRUPT_EN is defined.
module tb_elab_seq_gen;
    logic clk;
    logic rst_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    elab_seq_gen_if #(.WIDTH(4)) bus1 ();
    elab_seq_gen_if #(.WIDTH(4)) bus3 ();

    elab_seq_gen #(.WIDTH(4), .GAP(1)) dut_g1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    elab_seq_gen #(.WIDTH(4), .GAP(3)) dut_g3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_pat(input string tag,
                           input logic [3:0] o_vect, input logic o_trig, input logic o_busy,
                           input logic o_done, input logic o_ready,
                           input logic [3:0] e_vect, input logic e_trig, input logic e_busy,
                           input logic e_done, input logic e_ready);
        chk({tag, "_vect"},  32'(o_vect),  32'(e_vect));
        chk({tag, "_trig"},  32'(o_trig),  32'(e_trig));
        chk({tag, "_busy"},  32'(o_busy),  32'(e_busy));
        chk({tag, "_done"},  32'(o_done),  32'(e_done));
        chk({tag, "_ready"}, 32'(o_ready), 32'(e_ready));
    endtask

    // Scoreboard pop for the GAP=1 instance
    task automatic chk_g1(input string tag, input logic e_trig, input logic e_busy,
                          input logic e_done, input logic e_ready);
        logic [3:0] ev;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            ev = exp_q.pop_front();
            chk_pat(tag, bus1.vect, bus1.trig, bus1.busy, bus1.done, bus1.ready,
                    ev, e_trig, e_busy, e_done, e_ready);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
`ifdef ELAB_SEQ_GEN_CORRUPT_EN
        bus1.corrupt = 1'b0;
        bus1.corrupt_idx = 2'd0;
        bus3.corrupt = 1'b0;
        bus3.corrupt_idx = 2'd0;
`endif

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk_pat("rst_g1", bus1.vect, bus1.trig, bus1.busy, bus1.done, bus1.ready,
                4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_drop", 32'(bus1.drop_cnt), 32'd0);
        chk("rst_state", 32'(bus1.fsm_state), 32'd0);
        chk_pat("rst_g3", bus3.vect, bus3.trig, bus3.busy, bus3.done, bus3.ready,
                4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // T1: reset mid-pattern clears outputs without a clock edge
        bus1.start = 1'b1;
        cyc();
        bus1.start = 1'b0;
        chk("t1_c1_vect", 32'(bus1.vect), 32'h8);
        chk("t1_c1_state", 32'(bus1.fsm_state), 32'd1);
        cyc();
        chk("t1_c2_vect", 32'(bus1.vect), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk_pat("t1_async", bus1.vect, bus1.trig, bus1.busy, bus1.done, bus1.ready,
                4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_drop", 32'(bus1.drop_cnt), 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // T2: single pattern
        exp_q = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
        for (int c = 0; c <= 5; c++) begin
            chk_g1($sformatf("t2_c%0d", c), (c == 1), (c >= 1 && c <= 4), (c == 4),
                   (c == 0 || c == 4 || c == 5));
            bus1.start = (c == 0);
            cyc();
        end
        bus1.start = 1'b0;

        // T3: back-to-back, new request lands in the final step cycle
        exp_q = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
        for (int c = 0; c <= 9; c++) begin
            chk_g1($sformatf("t3_c%0d", c), (c == 1 || c == 5), (c >= 1 && c <= 8),
                   (c == 4 || c == 8), (c == 0 || c == 4 || c == 8 || c == 9));
            bus1.start = (c == 0 || c == 4);
            cyc();
        end
        bus1.start = 1'b0;
        chk("t3_drop", 32'(bus1.drop_cnt), 32'd0);

        // T4: overrun, cycle-2 and cycle-3 requests are dropped
        exp_q = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
        for (int c = 0; c <= 5; c++) begin
            chk_g1($sformatf("t4_c%0d", c), (c == 1), (c >= 1 && c <= 4), (c == 4),
                   (c == 0 || c == 4 || c == 5));
            bus1.start = (c == 0 || c == 2 || c == 3);
            cyc();
        end
        bus1.start = 1'b0;
        chk("t4_drop2", 32'(bus1.drop_cnt), 32'd2);

        // T4b: start held 400 cycles gives ~300 drops, counter saturates
        bus1.start = 1'b1;
        repeat (400) cyc();
        bus1.start = 1'b0;
        chk("t4_sat", 32'(bus1.drop_cnt), 32'd255);
        repeat (6) cyc();
        chk("t4_sat_idle", 32'(bus1.busy), 32'd0);
        bus1.start = 1'b1;
        cyc();
        bus1.start = 1'b0;
        repeat (2) cyc();
        chk("t4_sat_hold", 32'(bus1.drop_cnt), 32'd255);
        repeat (4) cyc();

        // T5: GAP=3, each step held 3 cycles, done at cycle 12
        for (int c = 0; c <= 13; c++) begin
            logic [3:0] ev;
            ev = (c >= 1 && c <= 12) ? (4'h8 >> ((c - 1) / 3)) : 4'h0;
            chk_pat($sformatf("t5_c%0d", c), bus3.vect, bus3.trig, bus3.busy, bus3.done,
                    bus3.ready, ev, (c == 1), (c >= 1 && c <= 12), (c == 12),
                    (c == 0 || c == 12 || c == 13));
            bus3.start = (c == 0);
            cyc();
        end
        bus3.start = 1'b0;

`ifdef ELAB_SEQ_GEN_CORRUPT_EN
        // T6: idx 2 step blanked, timing unchanged
        exp_q = '{4'h0, 4'h8, 4'h0, 4'h2, 4'h1, 4'h0};
        for (int c = 0; c <= 5; c++) begin
            chk_g1($sformatf("t6_c%0d", c), (c == 1), (c >= 1 && c <= 4), (c == 4),
                   (c == 0 || c == 4 || c == 5));
            bus1.start = (c == 0);
            bus1.corrupt = (c == 0);
            bus1.corrupt_idx = 2'd2;
            cyc();
        end
        bus1.start = 1'b0;
        bus1.corrupt = 1'b0;
`endif

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
